// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

    // Transaction phases of the host-to-device transmitter.
    typedef enum logic [2:0] {
        PS2_IDLE      = 3'd0,
        PS2_INHIBIT   = 3'd1,
        PS2_DATALOW   = 3'd2,
        PS2_SHIFT     = 3'd3,
        PS2_ACK       = 3'd4,
        PS2_WAIT_IDLE = 3'd5
    } ps2_state_e;

    // Data bits + parity + stop clocked out after the start bit.
    localparam int FRAME_BITS = 10;
    // The device clock fall on which the ACK bit is sampled.
    localparam int ACK_EDGE = 11;

    // Common keyboard commands.
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bits sent LSB first after the start bit: data, parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

    // Larger of two integers, for sizing shared counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus run-length glitch filter for one raw PS/2 line.
// The filtered value only changes after FILTER_LEN consecutive samples
// that disagree with it; both lines idle high, so everything resets to 1.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive samples that differ from the filtered value.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = {CW{1'b0}};
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
                cnt_d  = {CW{1'b0}};
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Two-stage synchroniser and filter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start bit, then the
// device clocks out data/parity/stop and returns an ACK on the 11th fall.
// A 1 on either oe output pulls the corresponding open-drain line low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3409,
    parameter int DATALOW_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 426135,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err_timeout,
    output logic       err_noack
);

    import ps2_pkg::*;

    localparam logic [2:0] S_IDLE      = 3'(PS2_IDLE);
    localparam logic [2:0] S_INHIBIT   = 3'(PS2_INHIBIT);
    localparam logic [2:0] S_DATALOW   = 3'(PS2_DATALOW);
    localparam logic [2:0] S_SHIFT     = 3'(PS2_SHIFT);
    localparam logic [2:0] S_ACK       = 3'(PS2_ACK);
    localparam logic [2:0] S_WAIT_IDLE = 3'(PS2_WAIT_IDLE);

    // One counter serves the fixed-length phases and the device timeout.
    localparam int MAX_CNT = max_int(max_int(INHIBIT_CYCLES, DATALOW_CYCLES), TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DL_LAST  = CNT_W'(DATALOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_DATA_EDGE = 4'(FRAME_BITS - 1);

    logic                  clk_filt_s;
    logic                  data_filt_s;
    logic                  fall_s;
    logic                  tmo_s;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            edge_q, edge_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  noack_q, noack_d;
    logic                  clk_prev_q;
    logic                  clk_oe_q, clk_oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  rx_inhibit_q, rx_inhibit_d;
    logic                  done_q, done_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_noack_q, err_noack_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_clk_in),
        .line_out (clk_filt_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_data_in),
        .line_out (data_filt_s)
    );

    assign fall_s = clk_prev_q & ~clk_filt_s;
    assign tmo_s  = (cnt_q == TMO_LAST);

    // Next-state, frame shifting and registered-output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        edge_d        = edge_q;
        frame_d       = frame_q;
        noack_d       = noack_q;
        data_oe_d     = data_oe_q;
        done_d        = 1'b0;
        err_timeout_d = 1'b0;
        err_noack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    frame_d = build_frame(tx_data);
                    edge_d  = 4'd0;
                    cnt_d   = {CNT_W{1'b0}};
                    noack_d = 1'b0;
                    state_d = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_INHIBIT: begin
                data_oe_d = 1'b0;
                if (cnt_q == INH_LAST) begin
                    cnt_d     = {CNT_W{1'b0}};
                    data_oe_d = 1'b1;
                    state_d   = S_DATALOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATALOW: begin
                data_oe_d = 1'b1;
                if (cnt_q == DL_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (tmo_s) begin
                    data_oe_d     = 1'b0;
                    done_d        = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (fall_s) begin
                    cnt_d     = {CNT_W{1'b0}};
                    edge_d    = edge_q + 4'd1;
                    data_oe_d = ~frame_q[edge_q];
                    if (edge_q == LAST_DATA_EDGE) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ACK: begin
                data_oe_d = 1'b0;
                if (tmo_s) begin
                    done_d        = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (fall_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    edge_d  = 4'(ACK_EDGE);
                    noack_d = data_filt_s;
                    state_d = S_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (tmo_s) begin
                    done_d        = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (clk_filt_s && data_filt_s) begin
                    done_d      = 1'b1;
                    err_noack_d = noack_q;
                    state_d     = S_IDLE;
                end else if (fall_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        clk_oe_d     = (state_d == S_INHIBIT) || (state_d == S_DATALOW);
        rx_inhibit_d = (state_d != S_IDLE);
        // Hold off a new request during the done cycle itself.
        tx_ready_d   = (state_d == S_IDLE) && !done_d;
    end

    // Transaction state and registered outputs; reset frees both lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            edge_q        <= 4'd0;
            frame_q       <= {FRAME_BITS{1'b0}};
            noack_q       <= 1'b0;
            clk_prev_q    <= 1'b1;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            tx_ready_q    <= 1'b1;
            rx_inhibit_q  <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_noack_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            edge_q        <= edge_d;
            frame_q       <= frame_d;
            noack_q       <= noack_d;
            clk_prev_q    <= clk_filt_s;
            clk_oe_q      <= clk_oe_d;
            data_oe_q     <= data_oe_d;
            tx_ready_q    <= tx_ready_d;
            rx_inhibit_q  <= rx_inhibit_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_noack_q   <= err_noack_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign rx_inhibit  = rx_inhibit_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign err_noack   = err_noack_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the opposite direction to the existing ps2 keyboard receiver.
- Sends single command bytes to the keyboard, such as 0xED set-LEDs followed by its LED mask, over the shared open-drain ps2Clk/ps2Data lines.
- Sits in the msx top level on cpuClock, beside the ps2 instance. The top level builds the tristates from the oe outputs, so a 1 on an oe output drives the line low.
- Asserts rx_inhibit for the whole transaction so the receiver ignores line activity.

Parameters:
- INHIBIT_CYCLES, default 3409: clock-low request-to-send time. 3409 cycles is 120 us at 28.409 MHz.
- DATALOW_CYCLES, default 16: cycles with both lines held low before the clock is released.
- TIMEOUT_CYCLES, default 426135: maximum gap between device clock edges. 426135 cycles is 15 ms.
- FILTER_LEN, default 8: consecutive equal samples needed to change a filtered line value.

Ports:
- clk, in, 1: system clock (cpuClock).
- rst_n, in, 1: asynchronous active-low reset.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: request. A byte is accepted on a cycle where tx_valid and tx_ready are both high.
- tx_ready, out, 1: high only in IDLE.
- ps2_clk_in, in, 1: raw ps2Clk pin level (asynchronous).
- ps2_data_in, in, 1: raw ps2Data pin level (asynchronous).
- ps2_clk_oe, out, 1: 1 pulls ps2Clk low.
- ps2_data_oe, out, 1: 1 pulls ps2Data low.
- rx_inhibit, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse at the end of a transaction (success or error).
- err_timeout, out, 1: valid only while done is high. The device stopped clocking.
- err_noack, out, 1: valid only while done is high. The device did not ACK.

Behaviour:
- Reset values: all outputs are 0 except tx_ready, which is 1. Reset is asynchronous and releases both lines immediately, including mid-frame. The state returns to IDLE.
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser, then a FILTER_LEN counter filter. Filtered values reset to 1.
  - fall = filtered clock 1 then 0 on consecutive cycles.
- On accept:
  - Latch frame[9:0] = {1'b1 stop, parity, tx_data}, where parity = ~^tx_data (odd parity).
  - Clear the edge counter to 0 and go to INHIBIT.
- IDLE: both oe = 0, tx_ready = 1. tx_valid is ignored in every other state.
- INHIBIT: clk_oe = 1, data_oe = 0, held for INHIBIT_CYCLES cycles. Then go to DATALOW.
- DATALOW: clk_oe = 1, data_oe = 1 (start bit), held for DATALOW_CYCLES cycles. Then go to SHIFT with clk_oe = 0 and the timeout counter cleared.
- SHIFT:
  - data_oe stays 1 until the first fall.
  - On fall number k (k = 1..10): data_oe <= ~frame[k-1], and edge count k is recorded.
  - After fall 10 data_oe = 0 (stop bit, line released). Go to ACK.
- ACK: on the next fall (fall 11), sample filtered data.
  - Data = 0: ACK received; go to WAIT_IDLE.
  - Data = 1: set the noack flag; go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock = 1 and filtered data = 1. Then pulse done with err_noack = noack flag, and go to IDLE on the same edge.
- Timeout:
  - In SHIFT, ACK and WAIT_IDLE the timeout counter increments every cycle and clears on each fall.
  - When it reaches TIMEOUT_CYCLES-1: both oe = 0, done = 1, err_timeout = 1, next state IDLE.
  - Timeout takes priority over a fall in the same cycle.
- Latency:
  - tx_ready falls the cycle after accept.
  - Earliest possible next accept is the cycle after done.
- Device clocking while in INHIBIT or DATALOW is not counted as a fall.
- Counters are wide enough for TIMEOUT_CYCLES and do not wrap.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, DATALOW, SHIFT, ACK, WAIT_IDLE);
  - FRAME_BITS = 10;
  - ACK_EDGE = 11;
  - keyboard command constants CMD_SET_LEDS = 8'hED and CMD_RESET = 8'hFF.
- One sub-module: ps2_line_filter (synchroniser plus counter filter), instantiated twice. The receiver may reuse it later.

Test Plan:
- Send 0xED; a device model clocks at 12.5 kHz and ACKs. Expect:
  - clk_oe held 3409 cycles, then data_oe 16 cycles with clk_oe = 1;
  - data line after falls 1..10 = 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done with both error flags 0.
- Send 0x01. Expect parity bit 0 after fall 9, done, no errors.
- Device model drives data high at fall 11 (no ACK). Expect done with err_noack = 1 and err_timeout = 0.
- Device stops clocking after fall 4. Expect done with err_timeout = 1 exactly TIMEOUT_CYCLES after fall 4, and both oe = 0.
- Assert rst_n = 0 during SHIFT. Expect clk_oe = data_oe = 0 with no clock edge needed, tx_ready = 1 after release, and a following 0xFF transfer completing normally.
- Pulse tx_valid with 0x55 mid-transfer and inject 3-cycle glitches on ps2_clk_in. Expect the second byte ignored (tx_ready low), no extra falls counted, and rx_inhibit high from accept until done.
